// File: rtl/alu_op_sequencer_pkg.sv
// Shared constants, state encoding and helpers for the ALU issue sequencer.
package alu_seq_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  // ALU op encoding: bit 2 = subtract, bits [1:0] = and/or/arith/slt
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } seq_state_e;

  // Replicate imm[15] into the upper half.
  function automatic logic [31:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Purely combinational instruction decode: opcode/funct -> ALU op and
// operand-select controls. Anything not in the table is flagged illegal.
module alu_op_decode
  import alu_seq_pkg::*;
(
  input  logic [31:0] instr,
  output logic [2:0]  alu_op,
  output logic        use_imm,
  output logic        is_beq,
  output logic        illegal
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_bits;

  assign opcode      = instr[31:26];
  assign funct       = instr[5:0];
  // Register/immediate fields are not needed for decode.
  assign unused_bits = ^instr[25:6];

  // Table lookup; default is "illegal" so unknown encodings fall through safely.
  always_comb begin
    alu_op  = ALU_AND;
    use_imm = 1'b0;
    is_beq  = 1'b0;
    illegal = 1'b1;
    case (opcode)
      OPC_RTYPE: begin
        illegal = 1'b0;
        case (funct)
          FUNCT_ADD: alu_op = ALU_ADD;
          FUNCT_SUB: alu_op = ALU_SUB;
          FUNCT_AND: alu_op = ALU_AND;
          FUNCT_OR:  alu_op = ALU_OR;
          FUNCT_SLT: alu_op = ALU_SLT;
          default:   illegal = 1'b1;
        endcase
      end
      OPC_ADDI: begin
        alu_op  = ALU_ADD;
        use_imm = 1'b1;
        illegal = 1'b0;
      end
      OPC_BEQ: begin
        alu_op  = ALU_SUB;
        is_beq  = 1'b1;
        illegal = 1'b0;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle issue controller for an external combinational ALU.
// Handshakes: a transfer happens on a rising edge where valid && ready;
// valid, once raised, holds with its payload stable until that edge.
module alu_op_sequencer
  import alu_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_z,
  input  logic        alu_ex,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        zero,
  output logic        taken,
  output logic        illegal
);

  seq_state_e  state_q, state_d;
  logic [31:0] alu_a_q, alu_a_d;
  logic [31:0] alu_b_q, alu_b_d;
  logic [2:0]  alu_op_q, alu_op_d;
  logic        is_beq_q, is_beq_d;
  logic [31:0] result_q, result_d;
  logic        zero_q, zero_d;
  logic        taken_q, taken_d;
  logic        illegal_q, illegal_d;

  logic [2:0]  dec_op;
  logic        dec_use_imm;
  logic        dec_is_beq;
  logic        dec_illegal;

  alu_op_decode u_decode (
    .instr   (instr),
    .alu_op  (dec_op),
    .use_imm (dec_use_imm),
    .is_beq  (dec_is_beq),
    .illegal (dec_illegal)
  );

  // Next-state and register-update logic for IDLE -> ISSUE -> RESP.
  always_comb begin
    state_d   = state_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_op_d  = alu_op_q;
    is_beq_d  = is_beq_q;
    result_d  = result_q;
    zero_d    = zero_q;
    taken_d   = taken_q;
    illegal_d = illegal_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (dec_illegal) begin
            // ALU operands keep their previous values; respond directly.
            illegal_d = 1'b1;
            result_d  = '0;
            zero_d    = 1'b0;
            taken_d   = 1'b0;
            state_d   = RESP;
          end else begin
            alu_a_d   = rs_val;
            alu_b_d   = dec_use_imm ? sext16(instr[15:0]) : rt_val;
            alu_op_d  = dec_op;
            is_beq_d  = dec_is_beq;
            illegal_d = 1'b0;
            state_d   = ISSUE;
          end
        end
      end
      ISSUE: begin
        // ALU has had a full cycle to settle on the registered operands.
        result_d = alu_z;
        zero_d   = alu_ex;
        taken_d  = is_beq_q & alu_ex;
        state_d  = RESP;
      end
      RESP: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_op_q  <= '0;
      is_beq_q  <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_op_q  <= alu_op_d;
      is_beq_q  <= is_beq_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      taken_q   <= taken_d;
      illegal_q <= illegal_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == RESP);
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign taken     = taken_q;
  assign illegal   = illegal_q;

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Multi-cycle issue controller that drives the 32-bit combinational ALU from the instruction side. It accepts one decoded-register instruction per handshake and translates opcode/funct into the 3-bit ALU op. It presents registered operands to the ALU, captures the result and zero flag, and returns them with a branch-taken indication on a valid/ready output channel. The block sits between the register-read stage and writeback in the lab datapath.

## Interface
- No parameters; the datapath width is fixed at 32.
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset, asynchronous and active-low
- in_valid  in  1  instruction and operands valid
- in_ready  out  1  block can accept (high only in IDLE)
- instr  in  32  instruction word: opcode [31:26], funct [5:0], imm [15:0]
- rs_val  in  32  first source operand
- rt_val  in  32  second source operand
- alu_a, alu_b  out  32  registered ALU operands
- alu_op  out  3  registered ALU op: bit 2 = subtract; bits [1:0] select 00 and, 01 or, 10 arith, 11 slt
- alu_z  in  32  ALU result (combinational from alu_a/alu_b/alu_op)
- alu_ex  in  1  ALU zero flag (1 when alu_z == 0)
- out_valid  out  1  response valid
- out_ready  in  1  consumer accepts response
- result  out  32  captured ALU result
- zero  out  1  captured alu_ex
- taken  out  1  beq and zero
- illegal  out  1  unsupported opcode/funct

## Operation
- Decode table:
  - R-type (opcode 000000) by funct:
    - 100000 add → op 010
    - 100010 sub → op 110
    - 100100 and → op 000
    - 100101 or → op 001
    - 101010 slt → op 111
  - addi (001000) → op 010, with b = sign-extended imm.
  - beq (000100) → op 110, with b = rt_val.
  - Everything else, including an R-type with an unknown funct, is illegal.
- FSM states: IDLE, ISSUE, RESP.
  - IDLE: in_ready=1. On in_valid, latch alu_a=rs_val, alu_b (rt_val or sext(imm)), alu_op and the beq bit.
    - Legal instruction → ISSUE.
    - Illegal instruction → RESP with illegal=1, result=0, zero=0, taken=0; the ALU outputs hold their previous values.
  - ISSUE: the ALU settles during this cycle. At the clock edge, capture result=alu_z and zero=alu_ex, and set taken = beq & alu_ex → RESP.
  - RESP: out_valid=1. result, zero, taken and illegal are held stable until out_ready, then → IDLE.
- Arithmetic is two's-complement modulo 2^32; overflow is not flagged.
- Sign extension replicates imm[15] into bits [31:16].
- No new instruction is accepted while a response is pending. No skid buffer is provided.

## Timing
- Accept at edge N (in_valid & in_ready):
  - alu_* are valid from N+1.
  - out_valid rises at N+2 for a legal instruction, or N+1 for an illegal one.
- When out_ready is high at the first RESP edge, the next accept is possible at N+3. This gives a throughput of 1 instruction per 3 cycles.
- in_ready is low in ISSUE and RESP, including in the cycle where out_ready completes the response. It returns high the cycle after.
- in_valid in IDLE coinciding with out_ready has no interaction, because the states are exclusive.
- Reset value of every output:
  - in_ready=1 (combinational from state IDLE).
  - out_valid=0.
  - alu_a, alu_b, result: 0.
  - alu_op=000.
  - zero, taken, illegal: 0.
- Reset asserted mid-operation (ISSUE or RESP) returns to IDLE immediately. Any pending response is discarded with no out_valid pulse.
- out_valid must not drop before out_ready is sampled high.

## Structure
- Shared package alu_seq_pkg holds:
  - Opcode and funct constants.
  - ALU op constants (AND, OR, ADD, SUB, SLT).
  - The state enum {IDLE, ISSUE, RESP}.
- One natural sub-module: alu_op_decode. It is purely combinational: instr → {alu_op, use_imm, is_beq, illegal}. It is instantiated once and reused by the decode unit tests.
- The FSM and output registers live in the top module. The ALU is external, with no instance inside this block.

## Test plan
- add: rs=7, rt=5, R funct 100000 → result=12, zero=0, taken=0, out_valid at accept+2.
- slt and sub signed: rs=0xFFFFFFFF (−1), rt=1.
  - slt (101010) → result=1.
  - sub → result=0xFFFFFFFE.
- addi sign-extension: rs=10, imm=0xFFFE → alu_b=0xFFFFFFFE, result=8.
- beq: rs=rt=0x1234 → zero=1, taken=1. Then rs=1, rt=2 → taken=0.
- Illegal opcode 111111 → out_valid at accept+1, illegal=1, result=0.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles → outputs stable and in_ready=0.
  - Assert rst_n=0 in RESP → out_valid=0 and in_ready=1 immediately.
